// File: rtl/fft_buf_pkg.sv
// fft_buf_pkg: shared states, core state codes, default sizes and the bit-reverse helper
// for the fft_sample_buffer block.
package fft_buf_pkg;
    localparam int N_DEFAULT = 1024;
    localparam int LOG2N_DEFAULT = 10;
    localparam int W_DEFAULT = 32;
    localparam logic [3:0] FFT_DONE = 4'd1;
    localparam logic [3:0] FFT_PROC = 4'd2;
    typedef enum logic [2:0] {LOAD, START, RUN, DRAIN, ACK} state_t;
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < bits; i++) r[bits-1-i] = v[i];
        return r;
    endfunction
endpackage

// File: rtl/fft_sample_buffer_if.sv
// fft_sample_buffer_if: sample stream, FFT core handshake/butterfly ports and spectrum stream.
interface fft_sample_buffer_if import fft_buf_pkg::*; #(
    parameter int LOG2N = LOG2N_DEFAULT,
    parameter int W = W_DEFAULT
);
    logic in_valid, in_ready;
    logic signed [W-1:0] in_data;
    logic fft_start, fft_ack, fft_done;
    logic [3:0] fft_state;
    logic [LOG2N-1:0] i_top, i_bot;
    logic signed [W-1:0] x_top_re, x_top_im, x_bot_re, x_bot_im;
    logic signed [W-1:0] y_top_re, y_top_im, y_bot_re, y_bot_im;
    logic out_valid, out_ready, out_last;
    logic signed [W-1:0] out_re, out_im;
    modport slave (
        input in_valid, in_data, fft_done, fft_state, i_top, i_bot,
        input y_top_re, y_top_im, y_bot_re, y_bot_im, out_ready,
        output in_ready, fft_start, fft_ack, x_top_re, x_top_im, x_bot_re, x_bot_im,
        output out_valid, out_re, out_im, out_last
    );
    modport master (
        output in_valid, in_data, fft_done, fft_state, i_top, i_bot,
        output y_top_re, y_top_im, y_bot_re, y_bot_im, out_ready,
        input in_ready, fft_start, fft_ack, x_top_re, x_top_im, x_bot_re, x_bot_im,
        input out_valid, out_re, out_im, out_last
    );
endinterface

// File: rtl/fft_buf_mem.sv
// fft_buf_mem: N x {re,im} sample memory, two write ports (bot wins on collision),
// three asynchronous read ports.
module fft_buf_mem import fft_buf_pkg::*; #(
    parameter int N = N_DEFAULT,
    parameter int LOG2N = LOG2N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic             clk,
    input  logic             we_top,
    input  logic [LOG2N-1:0] wa_top,
    input  logic [2*W-1:0]   wd_top,
    input  logic             we_bot,
    input  logic [LOG2N-1:0] wa_bot,
    input  logic [2*W-1:0]   wd_bot,
    input  logic [LOG2N-1:0] ra_top,
    input  logic [LOG2N-1:0] ra_bot,
    input  logic [LOG2N-1:0] ra_drn,
    output logic [2*W-1:0]   rd_top,
    output logic [2*W-1:0]   rd_bot,
    output logic [2*W-1:0]   rd_drn
);
    logic [2*W-1:0] mem [N];
    // bot write is issued last so it overrides top at the same address
    always_ff @(posedge clk) begin
        if (we_top) mem[wa_top] <= wd_top;
        if (we_bot) mem[wa_bot] <= wd_bot;
    end
    assign rd_top = mem[ra_top];
    assign rd_bot = mem[ra_bot];
    assign rd_drn = mem[ra_drn];
endmodule

// File: rtl/fft_sample_buffer.sv
// fft_sample_buffer: loads N real samples, sequences the FFT core Start/Ack, serves butterflies,
// drains the spectrum. Define FFT_BUF_BITREV_EN to load in bit-reversed order.
module fft_sample_buffer import fft_buf_pkg::*; #(
    parameter int N = N_DEFAULT,
    parameter int LOG2N = LOG2N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input logic Clk,
    input logic Reset,
    fft_sample_buffer_if.slave bus
);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
    state_t state;
    logic [LOG2N-1:0] cnt, load_addr, wa_top;
    logic load, wb, we_top;
    logic [2*W-1:0] wd_top, rd_top, rd_bot, rd_drn;
`ifdef FFT_BUF_BITREV_EN
    assign load_addr = LOG2N'(bitrev(32'(cnt), LOG2N));
`else
    assign load_addr = cnt;
`endif
    // the load stream shares the top write port; butterflies never run during LOAD
    always_comb begin
        load = state == LOAD && bus.in_valid;
        wb = state == RUN && bus.fft_state == FFT_PROC;
        we_top = load || wb;
        wa_top = load ? load_addr : bus.i_top;
        wd_top = load ? {bus.in_data, {W{1'b0}}} : {bus.y_top_re, bus.y_top_im};
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= LOAD;
            cnt <= '0;
            bus.in_ready <= 1'b1;
            bus.fft_start <= 1'b0;
            bus.fft_ack <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: if (bus.in_valid) begin
                    cnt <= cnt + LOG2N'(1);
                    if (cnt == LAST) begin
                        state <= START;
                        bus.in_ready <= 1'b0;
                        bus.fft_start <= 1'b1;
                    end
                end
                START: if (bus.fft_state == FFT_PROC) begin
                    state <= RUN;
                    bus.fft_start <= 1'b0;
                end
                RUN: if (bus.fft_done) begin
                    state <= DRAIN;
                    bus.out_valid <= 1'b1;
                end
                DRAIN: if (bus.out_ready) begin
                    cnt <= cnt + LOG2N'(1);
                    if (cnt == LAST) begin
                        state <= ACK;
                        bus.out_valid <= 1'b0;
                        bus.fft_ack <= 1'b1;
                    end
                end
                ACK: if (!bus.fft_done) begin
                    state <= LOAD;
                    bus.fft_ack <= 1'b0;
                    bus.in_ready <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end
    fft_buf_mem #(.N(N), .LOG2N(LOG2N), .W(W)) mem (
        .clk(Clk),
        .we_top(we_top),
        .wa_top(wa_top),
        .wd_top(wd_top),
        .we_bot(wb),
        .wa_bot(bus.i_bot),
        .wd_bot({bus.y_bot_re, bus.y_bot_im}),
        .ra_top(bus.i_top),
        .ra_bot(bus.i_bot),
        .ra_drn(cnt),
        .rd_top(rd_top),
        .rd_bot(rd_bot),
        .rd_drn(rd_drn)
    );
    assign {bus.x_top_re, bus.x_top_im} = rd_top;
    assign {bus.x_bot_re, bus.x_bot_im} = rd_bot;
    assign {bus.out_re, bus.out_im} = rd_drn;
    assign bus.out_last = bus.out_valid && cnt == LAST;
endmodule

// File: tb/tb_fft_sample_buffer.sv
// tb_fft_sample_buffer: directed scenarios for fft_sample_buffer (N=1024, W=32) against a
// reference memory; honours FFT_BUF_BITREV_EN for the expected load order.
module tb_fft_sample_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic signed [31:0] ref_re [1024];
    logic signed [31:0] ref_im [1024];

    fft_sample_buffer_if #(.LOG2N(10), .W(32)) bus ();
    fft_sample_buffer #(.N(1024), .LOG2N(10), .W(32)) dut (.Clk(clk), .Reset(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int brev(input int k);
`ifdef FFT_BUF_BITREV_EN
        int r = 0;
        for (int i = 0; i < 10; i++) r = r | (((k >> i) & 1) << (9 - i));
        return r;
`else
        return k;
`endif
    endfunction

    task automatic test_reset;
        @(posedge clk); @(posedge clk); #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        tests++; if (bus.fft_start !== 1'b0) begin fails++; $display("FAIL rst_fft_start got %b want 0", bus.fft_start); end
        tests++; if (bus.fft_ack !== 1'b0) begin fails++; $display("FAIL rst_fft_ack got %b want 0", bus.fft_ack); end
        tests++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin fails++; $display("FAIL rst_out got valid=%b last=%b want 0 0", bus.out_valid, bus.out_last); end
        rst = 1'b0;
    endtask

    task automatic test_load;
        int bad = 0;
        for (int k = 0; k < 1024; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = k;
            if (bus.in_ready !== 1'b1 || bus.fft_start !== 1'b0) bad++;
            ref_re[brev(k)] = k;
            ref_im[brev(k)] = 0;
            @(posedge clk); #1;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL load_ready_start got %0d bad cycles want 0", bad); end
        tests++; if (bus.fft_start !== 1'b1) begin fails++; $display("FAIL load_start_rise got %b want 1", bus.fft_start); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL load_in_ready_drop got %b want 0", bus.in_ready); end
        bus.i_top = 10'd1;
        bus.i_bot = 10'd2;
        #1;
        tests++; if (bus.x_top_re !== ref_re[1]) begin fails++; $display("FAIL load_x_top_re got %0d want %0d", bus.x_top_re, ref_re[1]); end
        tests++; if (bus.x_bot_re !== ref_re[2]) begin fails++; $display("FAIL load_x_bot_re got %0d want %0d", bus.x_bot_re, ref_re[2]); end
        tests++; if (bus.x_top_im !== 0 || bus.x_bot_im !== 0) begin fails++; $display("FAIL load_x_im got %0d/%0d want 0/0", bus.x_top_im, bus.x_bot_im); end
    endtask

    task automatic test_start_hold;
        int bad = 0;
        bus.fft_state = 4'd0;
        for (int c = 0; c < 5; c++) begin
            if (bus.fft_start !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        bus.fft_state = 4'd2;
        if (bus.fft_start !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        @(posedge clk); #1;
        bus.fft_state = 4'd3;
        bus.in_valid = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL start_hold got %0d bad cycles want 0", bad); end
        tests++; if (bus.fft_start !== 1'b0) begin fails++; $display("FAIL start_fall got %b want 0", bus.fft_start); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL start_in_ready got %b want 0", bus.in_ready); end
    endtask

    task automatic test_writeback;
        logic signed [31:0] old_top;
        bus.i_top = 10'd3;
        bus.i_bot = 10'd5;
        bus.y_top_re = 100; bus.y_top_im = -7;
        bus.y_bot_re = -1;  bus.y_bot_im = 2;
        bus.fft_state = 4'd2;
        #1;
        old_top = bus.x_top_re;
        tests++; if (old_top !== ref_re[3]) begin fails++; $display("FAIL wb_prewrite got %0d want %0d", old_top, ref_re[3]); end
        @(posedge clk); #1;
        bus.fft_state = 4'd3;
        ref_re[3] = 100; ref_im[3] = -7; ref_re[5] = -1; ref_im[5] = 2;
        tests++; if (bus.x_top_re !== 100 || bus.x_top_im !== -7) begin fails++; $display("FAIL wb_top got (%0d,%0d) want (100,-7)", bus.x_top_re, bus.x_top_im); end
        tests++; if (bus.x_bot_re !== -1 || bus.x_bot_im !== 2) begin fails++; $display("FAIL wb_bot got (%0d,%0d) want (-1,2)", bus.x_bot_re, bus.x_bot_im); end
        bus.y_top_re = 55; bus.y_top_im = 66; bus.y_bot_re = 77; bus.y_bot_im = 88;
        @(posedge clk); #1;
        tests++; if (bus.x_top_re !== 100 || bus.x_bot_re !== -1 || bus.x_bot_im !== 2) begin fails++; $display("FAIL wb_nowrite got top_re=%0d bot=(%0d,%0d) want 100 (-1,2)", bus.x_top_re, bus.x_bot_re, bus.x_bot_im); end
    endtask

    task automatic test_collision;
        bus.i_top = 10'd9;
        bus.i_bot = 10'd9;
        bus.y_top_re = 4; bus.y_top_im = 40;
        bus.y_bot_re = 8; bus.y_bot_im = 80;
        bus.fft_state = 4'd2;
        @(posedge clk); #1;
        bus.fft_state = 4'd3;
        ref_re[9] = 8; ref_im[9] = 80;
        tests++; if (bus.x_top_re !== 8 || bus.x_top_im !== 80) begin fails++; $display("FAIL collision got (%0d,%0d) want (8,80)", bus.x_top_re, bus.x_top_im); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL run_out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_drain;
        int b = 0;
        int cyc = 0;
        int bad_data = 0;
        int bad_last = 0;
        int bad_valid = 0;
        int bad_stall = 0;
        logic rdy = 1'b1;
        logic vld;
        logic signed [31:0] held;
        bus.fft_done = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL drain_valid_rise got %b want 1", bus.out_valid); end
        while (b < 1024 && cyc < 3000) begin
            vld = bus.out_valid;
            if (vld !== 1'b1) bad_valid++;
            if (bus.out_re !== ref_re[b] || bus.out_im !== ref_im[b]) bad_data++;
            if (bus.out_last !== (b == 1023)) bad_last++;
            held = bus.out_re;
            bus.out_ready = rdy;
            @(posedge clk); #1;
            if (vld && !rdy && bus.out_re !== held) bad_stall++;
            if (vld && rdy) b++;
            rdy = !rdy;
            cyc++;
        end
        bus.out_ready = 1'b0;
        tests++; if (b != 1024) begin fails++; $display("FAIL drain_count got %0d want 1024", b); end
        tests++; if (bad_valid != 0) begin fails++; $display("FAIL drain_valid got %0d low cycles want 0", bad_valid); end
        tests++; if (bad_data != 0) begin fails++; $display("FAIL drain_data got %0d bad beats want 0", bad_data); end
        tests++; if (bad_last != 0) begin fails++; $display("FAIL drain_last got %0d bad beats want 0", bad_last); end
        tests++; if (bad_stall != 0) begin fails++; $display("FAIL drain_stall got %0d unstable want 0", bad_stall); end
        tests++; if (bus.fft_ack !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL ack_rise got ack=%b valid=%b want 1 0", bus.fft_ack, bus.out_valid); end
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
        tests++; if (bus.fft_ack !== 1'b1 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL ack_hold got ack=%b ready=%b want 1 0", bus.fft_ack, bus.in_ready); end
        bus.fft_done = 1'b0;
        @(posedge clk); #1;
        tests++; if (bus.in_ready !== 1'b1 || bus.fft_ack !== 1'b0) begin fails++; $display("FAIL ack_release got ready=%b ack=%b want 1 0", bus.in_ready, bus.fft_ack); end
    endtask

    task automatic test_reset_mid;
        int b = 0;
        for (int k = 0; k < 1024; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 2000 + k;
            ref_re[brev(k)] = 2000 + k;
            ref_im[brev(k)] = 0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.fft_state = 4'd2;
        @(posedge clk); #1;
        bus.fft_state = 4'd3;
        bus.fft_done = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        while (b < 400 && bus.out_valid === 1'b1) begin @(posedge clk); #1; b++; end
        tests++; if (b != 400 || bus.out_re !== ref_re[400]) begin fails++; $display("FAIL mid_bin400 got bin=%0d re=%0d want 400 %0d", b, bus.out_re, ref_re[400]); end
        rst = 1'b1;
        #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.fft_ack !== 1'b0) begin fails++; $display("FAIL mid_rst_out got valid=%b ack=%b want 0 0", bus.out_valid, bus.fft_ack); end
        tests++; if (bus.in_ready !== 1'b1 || bus.out_last !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got ready=%b last=%b want 1 0", bus.in_ready, bus.out_last); end
        bus.out_ready = 1'b0;
        bus.fft_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_release_ready got %b want 1", bus.in_ready); end
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 7 + k;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.i_top = 10'(brev(0));
        bus.i_bot = 10'(brev(1));
        #1;
        tests++; if (bus.x_top_re !== 7 || bus.x_bot_re !== 8) begin fails++; $display("FAIL mid_reload got %0d/%0d want 7/8", bus.x_top_re, bus.x_bot_re); end
        tests++; if (bus.in_ready !== 1'b1 || bus.fft_start !== 1'b0) begin fails++; $display("FAIL mid_reload_state got ready=%b start=%b want 1 0", bus.in_ready, bus.fft_start); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = 0;
        bus.fft_done = 1'b0; bus.fft_state = 4'd0;
        bus.i_top = '0; bus.i_bot = '0;
        bus.y_top_re = 0; bus.y_top_im = 0; bus.y_bot_re = 0; bus.y_bot_im = 0;
        bus.out_ready = 1'b0;
        test_reset;
        test_load;
        test_start_hold;
        test_writeback;
        test_collision;
        test_drain;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
